// File: rtl/cpu_types_pkg.sv
// Shared types for the data-cache snoop agent: MSI states, snoop FSM states,
// frame geometry and address field helpers.
package cpu_types_pkg;

  localparam int TAG_W      = 25;
  localparam int IDX_W      = 4;
  localparam int NUM_FRAMES = 16;

  typedef enum logic [1:0] {
    MSI_I = 2'd0,
    MSI_S = 2'd1,
    MSI_M = 2'd2
  } msi_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_WB0    = 3'd2,
    ST_WB1    = 3'd3,
    ST_DONE   = 3'd4
  } snoop_state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31:7];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return a[6:3];
  endfunction

endpackage

// File: rtl/dcache_snoop_agent_if.sv
// Coherence bus between the snoop agent (master) and the bus/controller (slave).
interface dcache_snoop_agent_if;
  // ccwait is held by the bus while a snoop is pending; the agent may only
  // return to idle once ccwait drops. Each writeback beat (daddr/dstore) is
  // held stable and is accepted on the clock edge where dwait is low.
  logic        ccwait;
  logic        ccinv;
  logic [31:0] ccsnoopaddr;
  logic        dwait;
  logic        ccwrite;
  logic        cctrans;
  logic [31:0] daddr;
  logic [31:0] dstore;

  modport master (
    input  ccwait, ccinv, ccsnoopaddr, dwait,
    output ccwrite, cctrans, daddr, dstore
  );

  modport slave (
    output ccwait, ccinv, ccsnoopaddr, dwait,
    input  ccwrite, cctrans, daddr, dstore
  );
endinterface

// File: rtl/snoop_frame_array.sv
// 16-frame direct-mapped store: combinational lookup and snoop read ports,
// one write port shared by full-frame updates and snoop state changes.
module snoop_frame_array
  import cpu_types_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [TAG_W-1:0] lk_tag,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             lk_hit,
  output msi_t             lk_state,
  output logic [31:0]      lk_data0,
  output logic [31:0]      lk_data1,
  input  logic [IDX_W-1:0] snp_idx,
  output logic [TAG_W-1:0] snp_tag,
  output msi_t             snp_state,
  output logic [31:0]      snp_word0,
  output logic [31:0]      snp_word1,
  input  logic             full_wr_en,
  input  logic [TAG_W-1:0] full_wr_tag,
  input  logic [IDX_W-1:0] full_wr_idx,
  input  msi_t             full_wr_state,
  input  logic [31:0]      full_wr_word0,
  input  logic [31:0]      full_wr_word1,
  input  logic             st_wr_en,
  input  logic [IDX_W-1:0] st_wr_idx,
  input  msi_t             st_wr_state
);

  msi_t             state_mem [NUM_FRAMES];
  logic [TAG_W-1:0] tag_mem   [NUM_FRAMES];
  logic [31:0]      data0_mem [NUM_FRAMES];
  logic [31:0]      data1_mem [NUM_FRAMES];

  // Snoop state changes win the port; the FSM never issues both at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_FRAMES; i++) state_mem[i] <= MSI_I;
    end else if (st_wr_en) begin
      state_mem[st_wr_idx] <= st_wr_state;
    end else if (full_wr_en) begin
      state_mem[full_wr_idx] <= full_wr_state;
    end
  end

  always_ff @(posedge clk) begin
    if (full_wr_en && !st_wr_en) begin
      tag_mem[full_wr_idx]   <= full_wr_tag;
      data0_mem[full_wr_idx] <= full_wr_word0;
      data1_mem[full_wr_idx] <= full_wr_word1;
    end
  end

  always_comb begin
    lk_hit   = (state_mem[lk_idx] != MSI_I) && (tag_mem[lk_idx] == lk_tag);
    lk_state = lk_hit ? state_mem[lk_idx] : MSI_I;
    lk_data0 = lk_hit ? data0_mem[lk_idx] : 32'd0;
    lk_data1 = lk_hit ? data1_mem[lk_idx] : 32'd0;
  end

  assign snp_tag   = tag_mem[snp_idx];
  assign snp_state = state_mem[snp_idx];
  assign snp_word0 = data0_mem[snp_idx];
  assign snp_word1 = data1_mem[snp_idx];

endmodule

// File: rtl/dcache_snoop_agent.sv
// MSI snoop agent for a small direct-mapped data cache: answers bus snoops,
// writes back Modified blocks. Optional hit/writeback counters: SNOOP_STATS_EN.
module dcache_snoop_agent
  import cpu_types_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  dcache_snoop_agent_if.master  bus,
  input  logic [31:0]           lk_addr,
  output logic                  lk_hit,
  output logic [1:0]            lk_state,
  output logic [31:0]           lk_data0,
  output logic [31:0]           lk_data1,
  input  logic                  upd_en,
  input  logic [31:0]           upd_addr,
  input  logic [1:0]            upd_state,
  input  logic [31:0]           upd_word0,
  input  logic [31:0]           upd_word1,
  output logic                  upd_ready,
  input  logic                  tr_req,
  input  logic                  tr_wr,
  output logic [15:0]           snoop_hits,
  output logic [15:0]           snoop_wbs,
  output snoop_state_t          dbg_state
);

  snoop_state_t     state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  msi_t             lk_state_e, snp_state, st_wr_state;
  logic [TAG_W-1:0] snp_tag;
  logic [31:0]      snp_word0, snp_word1;
  logic             snp_hit, st_wr_en;
  logic             ccwrite, cctrans;
  logic [31:0]      daddr, dstore;
  logic             unused_bits;

  snoop_frame_array u_frames (
    .clk           (CLK),
    .rst           (RST),
    .lk_tag        (addr_tag(lk_addr)),
    .lk_idx        (addr_idx(lk_addr)),
    .lk_hit        (lk_hit),
    .lk_state      (lk_state_e),
    .lk_data0      (lk_data0),
    .lk_data1      (lk_data1),
    .snp_idx       (addr_idx(addr_q)),
    .snp_tag       (snp_tag),
    .snp_state     (snp_state),
    .snp_word0     (snp_word0),
    .snp_word1     (snp_word1),
    .full_wr_en    (upd_en && upd_ready),
    .full_wr_tag   (addr_tag(upd_addr)),
    .full_wr_idx   (addr_idx(upd_addr)),
    .full_wr_state (msi_t'(upd_state)),
    .full_wr_word0 (upd_word0),
    .full_wr_word1 (upd_word1),
    .st_wr_en      (st_wr_en),
    .st_wr_idx     (addr_idx(addr_q)),
    .st_wr_state   (st_wr_state)
  );

  assign lk_state    = lk_state_e;
  assign snp_hit     = (snp_state != MSI_I) && (snp_tag == addr_tag(addr_q));
  assign unused_bits = ^{lk_addr[2:0], upd_addr[2:0], bus.ccsnoopaddr[2:0]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    upd_ready   = 1'b0;
    cctrans     = 1'b0;
    ccwrite     = 1'b0;
    daddr       = 32'd0;
    dstore      = 32'd0;
    st_wr_en    = 1'b0;
    st_wr_state = MSI_I;
    case (state_q)
      ST_IDLE: begin
        if (bus.ccwait) begin
          addr_d  = {bus.ccsnoopaddr[31:3], 3'b000};
          state_d = ST_LOOKUP;
        end else begin
          // Requests from the cache side are masked while reset is held.
          upd_ready = 1'b1;
          cctrans   = tr_req && !RST;
          ccwrite   = tr_req && tr_wr && !RST;
        end
      end
      ST_LOOKUP: begin
        state_d = ST_DONE;
        if (snp_hit && snp_state == MSI_M) begin
          ccwrite = 1'b1;
          state_d = ST_WB0;
        end else if (snp_hit && bus.ccinv) begin
          st_wr_en = 1'b1;
        end
      end
      ST_WB0: begin
        daddr   = addr_q;
        dstore  = snp_word0;
        ccwrite = 1'b1;
        if (!bus.dwait) state_d = ST_WB1;
      end
      ST_WB1: begin
        daddr   = addr_q + 32'd4;
        dstore  = snp_word1;
        ccwrite = 1'b1;
        if (!bus.dwait) begin
          st_wr_en    = 1'b1;
          st_wr_state = bus.ccinv ? MSI_I : MSI_S;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!bus.ccwait) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ccwrite = ccwrite;
  assign bus.cctrans = cctrans;
  assign bus.daddr   = daddr;
  assign bus.dstore  = dstore;
  assign dbg_state   = state_q;

`ifdef SNOOP_STATS_EN
  logic        hit_pulse, wb_pulse;
  logic [15:0] hits_q, wbs_q;

  assign hit_pulse = (state_q == ST_LOOKUP) && snp_hit;
  assign wb_pulse  = (state_q == ST_WB1) && !bus.dwait;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hits_q <= 16'd0;
      wbs_q  <= 16'd0;
    end else begin
      if (hit_pulse && hits_q != 16'hFFFF) hits_q <= hits_q + 16'd1;
      if (wb_pulse && wbs_q != 16'hFFFF)   wbs_q  <= wbs_q + 16'd1;
    end
  end

  assign snoop_hits = hits_q;
  assign snoop_wbs  = wbs_q;
`else
  assign snoop_hits = 16'd0;
  assign snoop_wbs  = 16'd0;
`endif

endmodule

// File: tb/tb_dcache_snoop_agent.sv
// Bench for dcache_snoop_agent: directed snoop scenarios plus randomized
// update/snoop/lookup traffic against a frame-level MSI model.
module tb_dcache_snoop_agent;
  import cpu_types_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  dcache_snoop_agent_if bus ();

  logic [31:0]  lk_addr;
  logic         lk_hit;
  logic [1:0]   lk_state;
  logic [31:0]  lk_data0, lk_data1;
  logic         upd_en;
  logic [31:0]  upd_addr;
  logic [1:0]   upd_state;
  logic [31:0]  upd_word0, upd_word1;
  logic         upd_ready;
  logic         tr_req, tr_wr;
  logic [15:0]  snoop_hits, snoop_wbs;
  snoop_state_t dbg_state;

  dcache_snoop_agent dut (
    .CLK        (CLK),
    .RST        (RST),
    .bus        (bus),
    .lk_addr    (lk_addr),
    .lk_hit     (lk_hit),
    .lk_state   (lk_state),
    .lk_data0   (lk_data0),
    .lk_data1   (lk_data1),
    .upd_en     (upd_en),
    .upd_addr   (upd_addr),
    .upd_state  (upd_state),
    .upd_word0  (upd_word0),
    .upd_word1  (upd_word1),
    .upd_ready  (upd_ready),
    .tr_req     (tr_req),
    .tr_wr      (tr_wr),
    .snoop_hits (snoop_hits),
    .snoop_wbs  (snoop_wbs),
    .dbg_state  (dbg_state)
  );

  // ---------------- reference model + scoreboard ----------------
  logic [24:0] m_tag [16];
  logic [1:0]  m_st  [16];
  logic [31:0] m_w0  [16];
  logic [31:0] m_w1  [16];
  int          exp_hits, exp_wbs;
  logic [63:0] exp_q[$];
  int          total, bad;
  bit          tr_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    return (m_st[a[6:3]] != 2'd0) && (m_tag[a[6:3]] == a[31:7]);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [24:0] t;
    logic [3:0]  i;
    logic [2:0]  lo;
    t  = 25'($urandom_range(0, 2));
    i  = 4'($urandom_range(0, 15));
    lo = 3'($urandom_range(0, 7));
    return {t, i, lo};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_st[i] = 2'd0;
    exp_hits = 0;
    exp_wbs  = 0;
  endfunction

  // Random cache-side transaction requests.
  initial begin
    tr_req = 1'b0;
    tr_wr  = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      tr_req = tr_en ? 1'($urandom_range(0, 1)) : 1'b0;
      tr_wr  = tr_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (!RST) begin
      if (dbg_state == ST_WB0 || dbg_state == ST_WB1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wb_unexpected: got addr %h data %h want no beat", bus.daddr, bus.dstore);
        end else begin
          check("wb_beat", {bus.daddr, bus.dstore}, exp_q[0]);
          check("wb_ccwrite", 64'(bus.ccwrite), 64'd1);
          if (!bus.dwait) void'(exp_q.pop_front());
        end
      end else begin
        check("bus_quiet", {bus.daddr, bus.dstore}, 64'd0);
        if (dbg_state == ST_IDLE && !bus.ccwait) begin
          check("cctrans_idle", 64'(bus.cctrans), 64'(tr_req));
          check("ccwrite_idle", 64'(bus.ccwrite), 64'(tr_req & tr_wr));
        end else if (dbg_state != ST_IDLE) begin
          check("cctrans_busy", 64'(bus.cctrans), 64'd0);
          if (dbg_state == ST_DONE) check("ccwrite_done", 64'(bus.ccwrite), 64'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_update(input logic [31:0] a, input logic [1:0] st,
                           input logic [31:0] w0, input logic [31:0] w1);
    @(posedge CLK);
    #1;
    upd_en    = 1'b1;
    upd_addr  = a;
    upd_state = st;
    upd_word0 = w0;
    upd_word1 = w1;
    @(negedge CLK);
    check("upd_ready", 64'(upd_ready), 64'd1);
    @(posedge CLK);
    #1;
    upd_en = 1'b0;
    m_tag[a[6:3]] = a[31:7];
    m_st[a[6:3]]  = st;
    m_w0[a[6:3]]  = w0;
    m_w1[a[6:3]]  = w1;
  endtask

  task automatic check_lookup(input logic [31:0] a);
    logic [3:0] i;
    bit         h;
    @(posedge CLK);
    #1;
    lk_addr = a;
    @(negedge CLK);
    i = a[6:3];
    h = model_hit(a);
    check("lk_hit", 64'(lk_hit), 64'(h));
    check("lk_state", 64'(lk_state), h ? 64'(m_st[i]) : 64'd0);
    if (h) check("lk_data", {lk_data0, lk_data1}, {m_w0[i], m_w1[i]});
  endtask

  // hold >= 0: dwait held high for that many cycles once WB0 is reached.
  task automatic do_snoop(input logic [31:0] a, input bit inv, input bit collide,
                          input int hold, input int done_extra);
    logic [31:0] base;
    logic [3:0]  i;
    bit          done;
    base = {a[31:3], 3'b000};
    i    = a[6:3];
    if (model_hit(a)) begin
      if (exp_hits < 65535) exp_hits++;
      if (m_st[i] == 2'd2) begin
        exp_q.push_back({base, m_w0[i]});
        exp_q.push_back({base + 32'd4, m_w1[i]});
        m_st[i] = inv ? 2'd0 : 2'd1;
        if (exp_wbs < 65535) exp_wbs++;
      end else if (inv) begin
        m_st[i] = 2'd0;
      end
    end
    @(posedge CLK);
    #1;
    bus.ccwait      = 1'b1;
    bus.ccsnoopaddr = a;
    bus.ccinv       = inv;
    bus.dwait       = 1'b0;
    if (collide) begin
      upd_en    = 1'b1;
      upd_addr  = a;
      upd_state = 2'd2;
      upd_word0 = $urandom;
      upd_word1 = $urandom;
    end
    @(negedge CLK);
    if (collide) check("upd_blocked", 64'(upd_ready), 64'd0);
    done = 1'b0;
    for (int cyc = 1; cyc < 60 && !done; cyc++) begin
      @(posedge CLK);
      #1;
      upd_en = 1'b0;
      if (hold >= 0) bus.dwait = (cyc < 2 + hold);
      else           bus.dwait = (cyc < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (dbg_state == ST_DONE) done = 1'b1;
    end
    check("snoop_done", 64'(done), 64'd1);
    repeat (done_extra) begin
      @(posedge CLK);
      #1;
      check("done_hold", 64'(dbg_state), 64'(ST_DONE));
    end
    bus.ccwait = 1'b0;
    bus.dwait  = 1'b0;
    @(posedge CLK);
    #1;
    check("back_idle", 64'(dbg_state), 64'(ST_IDLE));
  endtask

  task automatic reset_in_wb1();
    bit seen;
    tr_en = 1'b0;
    do_update(32'h0000_0048, 2'd2, 32'h5555_0001, 32'h5555_0002);
    exp_q.push_back({32'h0000_0048, 32'h5555_0001});
    exp_q.push_back({32'h0000_004C, 32'h5555_0002});
    @(posedge CLK);
    #1;
    bus.ccwait      = 1'b1;
    bus.ccsnoopaddr = 32'h0000_0048;
    bus.ccinv       = 1'b0;
    bus.dwait       = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(posedge CLK);
      #1;
      if (dbg_state == ST_WB1) begin
        bus.dwait = 1'b1;
        seen = 1'b1;
      end
    end
    check("reach_wb1", 64'(seen), 64'd1);
    @(posedge CLK);
    #1;
    RST        = 1'b1;
    bus.ccwait = 1'b0;
    bus.dwait  = 1'b0;
    #1;
    check("rst_bus_out", {28'd0, bus.ccwrite, bus.cctrans, 2'd0, bus.daddr}, 64'd0);
    check("rst_dstore", 64'(bus.dstore), 64'd0);
    check("rst_upd_ready", 64'(upd_ready), 64'd1);
    check("rst_stats", {32'd0, snoop_hits, snoop_wbs}, 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_q.delete();
    model_reset();
    for (int i = 0; i < 16; i++) check_lookup({25'd0, 4'(i), 3'd0});
    check_lookup(32'h0000_0048);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    total = 0;
    bad   = 0;
    tr_en = 1'b0;
    lk_addr = 32'd0;
    upd_en = 1'b0; upd_addr = 32'd0; upd_state = 2'd0; upd_word0 = 32'd0; upd_word1 = 32'd0;
    bus.ccwait = 1'b0; bus.ccinv = 1'b0; bus.ccsnoopaddr = 32'd0; bus.dwait = 1'b0;
    model_reset();
    #12;
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    check("reset_upd_ready", 64'(upd_ready), 64'd1);
    check("reset_bus", {bus.daddr, bus.dstore}, 64'd0);
    check("reset_ctrl", {62'd0, bus.ccwrite, bus.cctrans}, 64'd0);
    check("reset_lk_hit", 64'(lk_hit), 64'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Modified block snooped without invalidate: writeback then Shared.
    do_update(32'h0000_0048, 2'd2, 32'hAAAA_0001, 32'hAAAA_0002);
    do_snoop(32'h0000_004C, 1'b0, 1'b0, 0, 0);
    check_lookup(32'h0000_0048);
    // Modified with invalidate and a stalled first beat.
    do_update(32'h0000_0048, 2'd2, 32'hAAAA_0001, 32'hAAAA_0002);
    do_snoop(32'h0000_0048, 1'b1, 1'b0, 3, 0);
    check_lookup(32'h0000_0048);
    // Shared block invalidated, DONE held until ccwait drops.
    do_update(32'h0000_0080, 2'd1, 32'hBBBB_0001, 32'hBBBB_0002);
    do_snoop(32'h0000_0080, 1'b1, 1'b0, -1, 2);
    check_lookup(32'h0000_0080);
    // Snoop beats a same-cycle update; cache requests live.
    tr_en = 1'b1;
    do_update(32'h0000_00C0, 2'd1, 32'hCCCC_0001, 32'hCCCC_0002);
    do_snoop(32'h0000_00C0, 1'b0, 1'b1, -1, 1);
    check_lookup(32'h0000_00C0);
    // Reset in the middle of the second writeback beat.
    reset_in_wb1();

    // Three hitting snoops, one of them a writeback.
    tr_en = 1'b1;
    do_update(32'h0000_0100, 2'd1, 32'h1111_0001, 32'h1111_0002);
    do_update(32'h0000_0108, 2'd2, 32'h2222_0001, 32'h2222_0002);
    do_snoop(32'h0000_0100, 1'b0, 1'b0, -1, 0);
    do_snoop(32'h0000_0104, 1'b1, 1'b0, -1, 0);
    do_snoop(32'h0000_0108, 1'b0, 1'b0, -1, 0);
    do_snoop(32'h0000_0200, 1'b0, 1'b0, -1, 0);
`ifdef SNOOP_STATS_EN
    check("stats_hits3", 64'(snoop_hits), 64'(exp_hits));
    check("stats_wbs1", 64'(snoop_wbs), 64'(exp_wbs));
`else
    check("stats_hits_off", 64'(snoop_hits), 64'd0);
    check("stats_wbs_off", 64'(snoop_wbs), 64'd0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = rand_addr();
      case ($urandom_range(0, 2))
        0: do_update(a, 2'($urandom_range(0, 2)), $urandom, $urandom);
        1: do_snoop(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), -1,
                    int'($urandom_range(0, 2)));
        default: check_lookup(a);
      endcase
      check_lookup(rand_addr());
    end

    @(posedge CLK);
    #1;
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
`ifdef SNOOP_STATS_EN
    check("stats_hits", 64'(snoop_hits), 64'(exp_hits));
    check("stats_wbs", 64'(snoop_wbs), 64'(exp_wbs));
`else
    check("stats_hits_off_end", 64'(snoop_hits), 64'd0);
    check("stats_wbs_off_end", 64'(snoop_wbs), 64'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
